// File: rtl/soc_it_pkg.sv
// Shared widths, FSM state encoding and tag-table entry for the SoC-IT master request arbiter.
package soc_it_pkg;

    localparam int TAG_W    = 4;
    localparam int TYPE_W   = 4;
    localparam int FLOW_W   = 10;
    localparam int ADDR_W   = 64;
    localparam int LEN_W    = 36;
    localparam int ERR_W    = 7;
    localparam int NUM_TAGS = 1 << TAG_W;

    // Owner field is sized for up to 16 requesters.
    localparam int OWNER_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_entry_t;

endpackage

// File: rtl/soc_it_master_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, one-hot out.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the requests starting at ptr, wrapping at N, and keep the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N))
                sum = sum - (IDX_W+1)'(N);
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_it_master_request_arbiter.sv
// Shares one SoC-IT master request port among NUM_REQ requesters, tracks
// outstanding tags and routes completions back to the owning requester.
module soc_it_master_request_arbiter
    import soc_it_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][TYPE_W-1:0]   req_type,
    input  logic [NUM_REQ-1:0][FLOW_W-1:0]   req_flow,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_local_address,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_length,
    output logic [NUM_REQ-1:0]               req_ack,

    output logic [NUM_REQ-1:0]               cpl_valid,
    output logic [TAG_W-1:0]                 cpl_tag,
    output logic [ERR_W-1:0]                 cpl_error,

    output logic                             master_request,
    output logic [TYPE_W-1:0]                master_request_type,
    output logic [FLOW_W-1:0]                master_request_flow,
    output logic [ADDR_W-1:0]                master_request_local_address,
    output logic [LEN_W-1:0]                 master_request_length,
    input  logic                             master_request_ack,
    input  logic                             master_request_complete,
    input  logic [TAG_W-1:0]                 master_request_tag,
    input  logic [ERR_W-1:0]                 master_request_error,

    output logic                             err_spurious_cpl,
    output logic                             err_tag_collision
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_e                      state;
    logic [IDX_W-1:0]                grant_idx;
    logic [IDX_W-1:0]                rr_ptr;
    logic [NUM_REQ-1:0][CNT_W-1:0]   out_cnt;
    tag_entry_t                      tag_tbl [NUM_TAGS];

    logic [NUM_REQ-1:0]              elig;
    logic [NUM_REQ-1:0]              gnt_oh;
    logic [IDX_W-1:0]                gnt_idx;
    logic                            ack_fire;
    logic                            cpl_fire;
    tag_entry_t                      cur_ent;
    logic [IDX_W-1:0]                cpl_owner;

    // A requester competes only while it has room for another outstanding tag.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (gnt_oh)
    );

    // One-hot grant to index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_oh[i])
                gnt_idx = IDX_W'(i);
    end

    // Ack and completion share master_request_tag, so both look up the same entry.
    assign cur_ent   = tag_tbl[master_request_tag];
    assign ack_fire  = (state == ST_REQ) && master_request_ack;
    assign cpl_fire  = master_request_complete && cur_ent.valid;
    assign cpl_owner = cur_ent.owner[IDX_W-1:0];

    // req_ack is same-cycle with the downstream accept.
    always_comb begin
        req_ack = '0;
        if (ack_fire)
            req_ack[grant_idx] = 1'b1;
    end

    // Request FSM: latch the winner on entry to REQ and hold its fields until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                        <= ST_IDLE;
            grant_idx                    <= '0;
            rr_ptr                       <= '0;
            master_request               <= 1'b0;
            master_request_type          <= '0;
            master_request_flow          <= '0;
            master_request_local_address <= '0;
            master_request_length        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        state                        <= ST_REQ;
                        grant_idx                    <= gnt_idx;
                        master_request               <= 1'b1;
                        master_request_type          <= req_type[gnt_idx];
                        master_request_flow          <= req_flow[gnt_idx];
                        master_request_local_address <= req_local_address[gnt_idx];
                        master_request_length        <= req_length[gnt_idx];
                    end
                end
                ST_REQ: begin
                    if (master_request_ack) begin
                        state                        <= ST_IDLE;
                        master_request               <= 1'b0;
                        master_request_type          <= '0;
                        master_request_flow          <= '0;
                        master_request_local_address <= '0;
                        master_request_length        <= '0;
                        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag table, completion routing and error flags; completion clears before ack allocates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpl_valid         <= '0;
            cpl_tag           <= '0;
            cpl_error         <= '0;
            err_spurious_cpl  <= 1'b0;
            err_tag_collision <= 1'b0;
            for (int t = 0; t < NUM_TAGS; t++)
                tag_tbl[t] <= '0;
        end else begin
            cpl_valid <= '0;
            if (master_request_complete) begin
                if (cur_ent.valid) begin
                    cpl_valid[cpl_owner]             <= 1'b1;
                    cpl_tag                          <= master_request_tag;
                    cpl_error                        <= master_request_error;
                    tag_tbl[master_request_tag].valid <= 1'b0;
                end else begin
                    err_spurious_cpl <= 1'b1;
                end
            end
            if (ack_fire) begin
                if (cur_ent.valid && !cpl_fire)
                    err_tag_collision <= 1'b1;
                tag_tbl[master_request_tag] <= '{valid: 1'b1, owner: OWNER_W'(grant_idx)};
            end
        end
    end

    // Outstanding counters; a simultaneous +1/-1 cancels and the ends saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_fire && (grant_idx == IDX_W'(i)) && !(cpl_fire && (cpl_owner == IDX_W'(i)))) begin
                    if (out_cnt[i] != CNT_W'(MAX_OUT))
                        out_cnt[i] <= out_cnt[i] + 1'b1;
                end else if (cpl_fire && (cpl_owner == IDX_W'(i)) && !(ack_fire && (grant_idx == IDX_W'(i)))) begin
                    if (out_cnt[i] != '0)
                        out_cnt[i] <= out_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_it_master_request_arbiter.sv
// Directed bench for the SoC-IT master request arbiter.
module tb_soc_it_master_request_arbiter;

    localparam int NR = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][3:0]   req_type;
    logic [NR-1:0][9:0]   req_flow;
    logic [NR-1:0][63:0]  req_local_address;
    logic [NR-1:0][35:0]  req_length;
    logic [NR-1:0]        req_ack;
    logic [NR-1:0]        cpl_valid;
    logic [3:0]           cpl_tag;
    logic [6:0]           cpl_error;
    logic                 master_request;
    logic [3:0]           master_request_type;
    logic [9:0]           master_request_flow;
    logic [63:0]          master_request_local_address;
    logic [35:0]          master_request_length;
    logic                 master_request_ack;
    logic                 master_request_complete;
    logic [3:0]           master_request_tag;
    logic [6:0]           master_request_error;
    logic                 err_spurious_cpl;
    logic                 err_tag_collision;

    int n_chk  = 0;
    int n_fail = 0;

    soc_it_master_request_arbiter #(.NUM_REQ(NR), .MAX_OUT(4)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .req_valid                    (req_valid),
        .req_type                     (req_type),
        .req_flow                     (req_flow),
        .req_local_address            (req_local_address),
        .req_length                   (req_length),
        .req_ack                      (req_ack),
        .cpl_valid                    (cpl_valid),
        .cpl_tag                      (cpl_tag),
        .cpl_error                    (cpl_error),
        .master_request               (master_request),
        .master_request_type          (master_request_type),
        .master_request_flow          (master_request_flow),
        .master_request_local_address (master_request_local_address),
        .master_request_length        (master_request_length),
        .master_request_ack           (master_request_ack),
        .master_request_complete      (master_request_complete),
        .master_request_tag           (master_request_tag),
        .master_request_error         (master_request_error),
        .err_spurious_cpl             (err_spurious_cpl),
        .err_tag_collision            (err_tag_collision)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] addr_of(input int r);
        return 64'hA5A5_0000_0000_0100 + 64'(r);
    endfunction

    function automatic logic [63:0] oh(input int r);
        return 64'(1) << r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                     = 1'b1;
        req_valid               = '0;
        master_request_ack      = 1'b0;
        master_request_complete = 1'b0;
        master_request_tag      = '0;
        master_request_error    = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Poll for master_request, bounded; returns cycles waited.
    task automatic wait_req(input string tag, output int cnt);
        cnt = 0;
        while (!master_request && cnt < 20) begin
            step();
            cnt++;
        end
        chk({tag, "_req"}, 64'(master_request), 64'd1);
    endtask

    // Wait for the next request, check the grant, ack it with tag tg.
    task automatic issue(input string tag, input int exp_r, input int tg, output int gap);
        wait_req(tag, gap);
        chk({tag, "_addr"}, master_request_local_address, addr_of(exp_r));
        master_request_ack = 1'b1;
        master_request_tag = 4'(tg);
        #1;
        chk({tag, "_ack"}, 64'(req_ack), oh(exp_r));
        @(posedge clk);
        #1;
        master_request_ack = 1'b0;
    endtask

    task automatic do_cpl(input int tg, input logic [6:0] er);
        master_request_complete = 1'b1;
        master_request_tag      = 4'(tg);
        master_request_error    = er;
        step();
        master_request_complete = 1'b0;
    endtask

    int gap;

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_type[i]          = 4'(i + 3);
            req_flow[i]          = 10'(100 + i);
            req_local_address[i] = addr_of(i);
            req_length[i]        = 36'(1000 + i);
        end

        // Reset state
        do_reset();
        chk("rst_mreq", 64'(master_request), 64'd0);
        chk("rst_addr", master_request_local_address, 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_cpl", 64'(cpl_valid), 64'd0);
        chk("rst_ctag", 64'(cpl_tag), 64'd0);
        chk("rst_errs", 64'({err_spurious_cpl, err_tag_collision}), 64'd0);

        // Round-robin order 0,1,2,3,0 with 2-cycle spacing
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            issue("rr", k % 4, k, gap);
            chk("rr_gap", 64'(gap), 64'd1);
        end
        req_valid = '0;

        // Single requester 2, ack in the 3rd request cycle with tag 5
        do_reset();
        req_valid = 4'b0100;
        wait_req("one", gap);
        chk("one_c1", master_request_local_address, addr_of(2));
        chk("one_type", 64'(master_request_type), 64'd5);
        chk("one_len", 64'(master_request_length), 64'd1002);
        step();
        chk("one_c2", master_request_local_address, addr_of(2));
        step();
        chk("one_c3", master_request_local_address, addr_of(2));
        issue("one", 2, 5, gap);
        req_valid = '0;
        chk("one_drop", 64'(master_request), 64'd0);
        do_cpl(5, 7'h03);
        chk("one_own", 64'(cpl_valid), oh(2));
        chk("one_ctag", 64'(cpl_tag), 64'd5);
        step();
        chk("one_pulse", 64'(cpl_valid), 64'd0);

        // Requester 1 saturates at 4 outstanding and is skipped
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) issue("sat_fill", 1, k, gap);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) issue("sat_skip", (k % 3 == 0) ? 2 : (k % 3 == 1) ? 3 : 0, 4 + k, gap);
        req_valid = '0;
        do_cpl(1, 7'h00);
        chk("sat_cpl", 64'(cpl_valid), oh(1));
        req_valid = 4'b1111;
        issue("sat_readmit", 1, 10, gap);
        req_valid = '0;

        // Completion routing and error code
        do_reset();
        req_valid = 4'b1000;
        issue("cpl", 3, 7, gap);
        req_valid = '0;
        do_cpl(7, 7'h15);
        chk("cpl_v", 64'(cpl_valid), oh(3));
        chk("cpl_tag", 64'(cpl_tag), 64'd7);
        chk("cpl_err", 64'(cpl_error), 64'h15);
        step();
        chk("cpl_pulse", 64'(cpl_valid), 64'd0);
        chk("cpl_hold", 64'(cpl_tag), 64'd7);

        // Spurious completion and tag collision
        do_cpl(9, 7'h11);
        chk("spur_flag", 64'(err_spurious_cpl), 64'd1);
        chk("spur_nocpl", 64'(cpl_valid), 64'd0);
        chk("spur_hold", 64'(cpl_error), 64'h15);
        req_valid = 4'b0001;
        issue("col_a", 0, 5, gap);
        req_valid = 4'b0010;
        chk("col_pre", 64'(err_tag_collision), 64'd0);
        issue("col_b", 1, 5, gap);
        req_valid = '0;
        chk("col_flag", 64'(err_tag_collision), 64'd1);
        do_cpl(5, 7'h01);
        chk("col_owner", 64'(cpl_valid), oh(1));

        // Same-cycle ack and complete on one tag: completion first, then allocation
        do_reset();
        req_valid = 4'b0100;
        issue("same_a", 2, 3, gap);
        req_valid = 4'b0001;
        wait_req("same_b", gap);
        master_request_ack      = 1'b1;
        master_request_complete = 1'b1;
        master_request_tag      = 4'd3;
        master_request_error    = 7'h2A;
        #1;
        chk("same_ack", 64'(req_ack), oh(0));
        @(posedge clk);
        #1;
        master_request_ack      = 1'b0;
        master_request_complete = 1'b0;
        req_valid               = '0;
        chk("same_cpl", 64'(cpl_valid), oh(2));
        chk("same_err", 64'(cpl_error), 64'h2A);
        chk("same_nocol", 64'(err_tag_collision), 64'd0);
        do_cpl(3, 7'h00);
        chk("same_realloc", 64'(cpl_valid), oh(0));

        // Reset in REQ with 3 tags outstanding
        do_reset();
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) issue("mid", k, k, gap);
        req_valid = 4'b1111;
        wait_req("mid_pend", gap);
        chk("mid_pend_addr", master_request_local_address, addr_of(3));
        rst                = 1'b1;
        master_request_ack = 1'b1;
        master_request_tag = 4'd8;
        #1;
        chk("mid_mreq", 64'(master_request), 64'd0);
        chk("mid_addr", master_request_local_address, 64'd0);
        chk("mid_ack", 64'(req_ack), 64'd0);
        master_request_ack = 1'b0;
        step();
        rst = 1'b0;
        issue("mid_restart", 0, 9, gap);
        req_valid = '0;
        do_cpl(0, 7'h00);
        chk("mid_tbl_clr", 64'(err_spurious_cpl), 64'd1);
        chk("mid_nocpl", 64'(cpl_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
